// File: rtl/emitter_pkg.sv
// Shared constants, state encoding and helpers for the UART byte emitter.
// Imported by the FIFO and the top-level serialiser.
package emitter_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // Baud divisor rounded to the nearest whole clock count.
    function automatic int f_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic logic f_parity(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/emitter_fifo.sv
// Synchronous first-word-fall-through FIFO with an exact occupancy count.
// A push is refused while full, even when a pop happens in the same cycle.
module emitter_fifo
    import emitter_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/emitter_uart_fifo.sv
// Byte-stream to UART emitter: buffers {tlast,tdata} in a FIFO and serialises
// each entry with optional parity, one or two stop bits and optional CR+LF after tlast.
module emitter_uart_fifo
    import emitter_pkg::*;
#(
    parameter int CLK_HZ    = 16000000,
    parameter int BAUD      = 57600,
    parameter int DEPTH     = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int EOL_EN    = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [7:0]             i_tdata,
    input  logic                   i_tlast,
    input  logic                   i_tvalid,
    output logic                   o_tready,
    output logic                   o_uart_tx,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int DIV   = f_div(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(DIV);

    if (DIV < 2) begin : g_chk_div
        $error("emitter_uart_fifo: baud divisor must be at least 2");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("emitter_uart_fifo: DEPTH must be a power of two >= 2");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_chk_parity
        $error("emitter_uart_fifo: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_chk_stop
        $error("emitter_uart_fifo: STOP_BITS must be 1 or 2");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               par_q, par_d;
    logic [1:0]         pend_q, pend_d;
    logic               tx_q, tx_d;
    logic               pop;
    logic               wrap;
    logic               fifo_full;
    logic               fifo_empty;
    logic [8:0]         fifo_dout;

    // Valid/ready: a byte moves when i_tvalid and o_tready are both high at a
    // rising edge; o_tready depends only on registered FIFO occupancy.
    assign o_tready = ~fifo_full;

    emitter_fifo #(
        .WIDTH (9),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (i_tvalid & o_tready),
        .pop   (pop),
        .din   ({i_tlast, i_tdata}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_level)
    );

    assign wrap = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        pend_d  = pend_q;
        pop     = 1'b0;
        tx_d    = 1'b1;

        if (state_q != ST_IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // Pending line-end characters take priority over further FIFO pops.
                if (pend_q != 2'd0) begin
                    shreg_d = (pend_q == 2'd2) ? CHAR_CR : CHAR_LF;
                    pend_d  = pend_q - 2'd1;
                    par_d   = f_parity(shreg_d, PARITY);
                    bit_d   = 3'd0;
                    state_d = ST_START;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout[7:0];
                    par_d   = f_parity(shreg_d, PARITY);
                    bit_d   = 3'd0;
                    if ((EOL_EN != 0) && fifo_dout[8]) pend_d = 2'd2;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (wrap) begin
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (wrap) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_PAR: begin
                if (wrap) begin
                    bit_d   = 3'd0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (wrap) begin
                    if (bit_q == 3'(STOP_BITS - 1)) state_d = ST_IDLE;
                    else                            bit_d   = bit_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level is computed for the next state so the register lands with it.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            ST_PAR:   tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            par_q   <= 1'b0;
            pend_q  <= 2'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            pend_q  <= pend_d;
            tx_q    <= tx_d;
        end
    end

    assign o_uart_tx = tx_q;
    assign o_busy    = (state_q != ST_IDLE) | (pend_q != 2'd0) | (o_level != '0);

endmodule
